// File: rtl/cntr_csr_pkg.sv
// Shared types and constants for the Zicntr CSR read front end and its cntrs port.
// Holds the CSR decode helper used at request accept time.
package cntr_csr_pkg;

  typedef logic [31:0] word_t;
  typedef logic [1:0]  cntr_t;

  localparam cntr_t CNTR_CYCLE   = 2'b00;
  localparam cntr_t CNTR_TIME    = 2'b01;
  localparam cntr_t CNTR_INSTRET = 2'b10;

  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_TIME     = 12'hC01;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_TIMEH    = 12'hC81;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic legal;
    logic idx;
    logic half;
  } dec_t;

  // time aliases cycle: bit 1 picks instret, bit 7 picks the high word
  function automatic dec_t csr_decode(input logic [11:0] csr, input logic wr);
    dec_t d;
    d.idx  = csr[1];
    d.half = csr[7];
    case (csr)
      CSR_CYCLE, CSR_TIME, CSR_INSTRET,
      CSR_CYCLEH, CSR_TIMEH, CSR_INSTRETH: d.legal = !wr;
      default:                             d.legal = 1'b0;
    endcase
    return d;
  endfunction

  function automatic cntr_t idx_addr(input logic idx);
    return idx ? CNTR_INSTRET : CNTR_CYCLE;
  endfunction

endpackage

// File: rtl/cntr_csr_hi_track.sv
// Per-counter high-word tracker: counts low-word wraps of a 32-bit hardware counter.
// Only instantiated when CNTR_HI_EN is defined.
module cntr_hi_track
  import cntr_csr_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  sample_en,
  input  word_t sample,
  output word_t hi,
  output logic  wrap
);

  word_t lo_prev;

  // A counter moves at most a few counts between samples, so a decrease is exactly one wrap
  assign wrap = sample_en && (sample < lo_prev);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_prev <= '0;
      hi      <= '0;
    end else if (sample_en) begin
      lo_prev <= sample;
      hi      <= hi + {31'b0, wrap};
    end
  end

endmodule

// File: rtl/cntr_csr.sv
// Zicntr CSR read front end: decodes cycle/time/instret(h) reads, fixed two-cycle response.
// Define CNTR_HI_EN to extend the 32-bit counters to 64 bits by snooping for wraps.
module cntr_csr
  import cntr_csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [11:0] req_csr,
  input  logic        req_wr,
  output logic        resp_valid,
  output word_t       resp_data,
  output logic        resp_illegal,
  output cntr_t       cntr_addr,
  input  word_t       cntr_data
);

  state_t state;
  state_t state_nxt;
  dec_t   dec_q;
  word_t  hi_read;
  cntr_t  snoop_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Illegal requests never address a counter; the bus keeps snooping instead
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    cntr_addr = snoop_addr;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        state_nxt = ST_RESP;
        if (dec_q.legal) cntr_addr = idx_addr(dec_q.idx);
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign resp_valid = (state == ST_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               dec_q <= '0;
    else if (state == ST_IDLE && req_valid) dec_q <= csr_decode(req_csr, req_wr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_data    <= '0;
      resp_illegal <= 1'b0;
    end else if (state == ST_ACCESS) begin
      resp_illegal <= !dec_q.legal;
      if (!dec_q.legal)    resp_data <= '0;
      else if (dec_q.half) resp_data <= hi_read;
      else                 resp_data <= cntr_data;
    end
  end

`ifdef CNTR_HI_EN
  logic       snoop_sel;
  word_t      hi_q [2];
  logic [1:0] wrap;

  // Alternate counters while not accessing so each is re-sampled within three cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     snoop_sel <= 1'b0;
    else if (state != ST_ACCESS) snoop_sel <= ~snoop_sel;
  end

  assign snoop_addr = snoop_sel ? CNTR_INSTRET : CNTR_CYCLE;

  for (genvar g = 0; g < 2; g++) begin : g_track
    cntr_hi_track u_track (
      .clk       (clk),
      .rst       (rst),
      .sample_en (cntr_addr[1] == 1'(g)),
      .sample    (cntr_data),
      .hi        (hi_q[g]),
      .wrap      (wrap[g])
    );
  end

  // Fold in a wrap seen by this very sample so the high word is never stale
  assign hi_read = hi_q[dec_q.idx] + {31'b0, wrap[dec_q.idx]};
`else
  assign snoop_addr = CNTR_CYCLE;
  assign hi_read    = '0;
`endif

endmodule

// File: tb/tb_cntr_csr.sv
// Scoreboard bench for cntr_csr: 64-bit reference counters drive cntrs.data,
// expected responses are queued at issue and matched by an independent monitor.
module tb_cntr_csr;
  import cntr_csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_csr;
  logic        req_wr;
  logic        resp_valid;
  word_t       resp_data;
  logic        resp_illegal;
  cntr_t       cntr_addr;
  word_t       cntr_data;

  always #5 clk = ~clk;

  cntr_csr dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_csr      (req_csr),
    .req_wr       (req_wr),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_illegal (resp_illegal),
    .cntr_addr    (cntr_addr),
    .cntr_data    (cntr_data)
  );

  // Reference counters are true 64-bit values; the DUT only ever sees the low halves
  logic [63:0] cyc_cnt;
  logic [63:0] ins_cnt;
  logic [31:0] inc_cyc;
  logic [31:0] inc_ins;
  logic        load_en;
  logic [31:0] load_cyc;
  logic [31:0] load_ins;
  logic        rand_inc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt <= {32'h0, load_en ? load_cyc : cyc_cnt[31:0]};
      ins_cnt <= {32'h0, load_en ? load_ins : ins_cnt[31:0]};
    end else begin
      cyc_cnt <= cyc_cnt + {32'h0, inc_cyc};
      ins_cnt <= ins_cnt + {32'h0, inc_ins};
    end
  end

  assign cntr_data = (cntr_addr == CNTR_INSTRET) ? ins_cnt[31:0] : cyc_cnt[31:0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        illegal;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   last_due = -10;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Response rules written directly from the CSR map: which counter, which half
  function automatic void model(input logic [11:0] csr, input logic wr,
                                input logic [63:0] c, input logic [63:0] i,
                                output logic [31:0] d, output logic ill);
    logic [63:0] hi_c;
    logic [63:0] hi_i;
`ifdef CNTR_HI_EN
    hi_c = c >> 32;
    hi_i = i >> 32;
`else
    hi_c = 64'h0;
    hi_i = 64'h0;
`endif
    ill = wr;
    d   = 32'h0;
    case (csr)
      12'hC00, 12'hC01: d = c[31:0];
      12'hC02:          d = i[31:0];
      12'hC80, 12'hC81: d = hi_c[31:0];
      12'hC82:          d = hi_i[31:0];
      default:          ill = 1'b1;
    endcase
    if (ill) d = 32'h0;
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checkOutput("req_ready", {63'h0, req_ready},
                  {63'h0, !(cyc >= last_due - 1 && cyc <= last_due)});
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_resp", 64'h1, 64'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("resp_latency", 64'(cyc), 64'(e.due));
          checkOutput("resp_data", {32'h0, resp_data}, {32'h0, e.data});
          checkOutput("resp_illegal", {63'h0, resp_illegal}, {63'h0, e.illegal});
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        checkOutput("missing_resp", 64'h0, 64'h1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(negedge clk);
    if (rand_inc) begin
      inc_cyc = $urandom_range(0, 4);
      inc_ins = $urandom_range(0, 4);
    end
  endtask

  // Call at a negedge; returns one negedge after the accepting edge (the ACCESS cycle)
  task automatic applyStimulus(input logic [11:0] csr, input logic wr, input logic burst,
                               output int acc_cyc);
    int guard;
    exp_t e;
    req_valid = 1'b1;
    req_csr   = csr;
    req_wr    = wr;
    guard     = 0;
    acc_cyc   = -1;
    while (!req_ready && guard < 20) begin
      step();
      guard++;
    end
    if (!req_ready) begin
      checkOutput("accept_timeout", 64'h0, 64'h1);
      req_valid = 1'b0;
      return;
    end
    if (burst) inc_ins = 32'd4;
    model(csr, wr, cyc_cnt + {32'h0, inc_cyc}, ins_cnt + {32'h0, inc_ins}, e.data, e.illegal);
    e.due    = cyc + 2;
    last_due = cyc + 2;
    acc_cyc  = cyc;
    exp_q.push_back(e);
    step();
    req_valid = 1'b0;
    if (burst) inc_ins = 32'd0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((exp_q.size() > 0 || cyc <= last_due) && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) checkOutput("idle_timeout", 64'h0, 64'h1);
    step();
  endtask

  task automatic do_reset(input logic [31:0] lc, input logic [31:0] li);
    step();
    rst      = 1'b1;
    load_en  = 1'b1;
    load_cyc = lc;
    load_ins = li;
    exp_q.delete();
    last_due = -10;
    step();
    step();
    rst     = 1'b0;
    load_en = 1'b0;
    step();
  endtask

  logic [11:0] csr_tab [10] = '{12'hC00, 12'hC01, 12'hC02, 12'hC80, 12'hC81,
                                 12'hC82, 12'hC83, 12'h300, 12'hC03, 12'hB00};

  initial begin
    int t0;
    int t1;
    rst = 1'b1; req_valid = 1'b0; req_csr = '0; req_wr = 1'b0;
    inc_cyc = 0; inc_ins = 0; rand_inc = 1'b0;
    load_en = 1'b1; load_cyc = 32'd5; load_ins = 32'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_req_ready", {63'h0, req_ready}, 64'h1);
    checkOutput("reset_resp_valid", {63'h0, resp_valid}, 64'h0);
    checkOutput("reset_resp_data", {32'h0, resp_data}, 64'h0);
    checkOutput("reset_resp_illegal", {63'h0, resp_illegal}, 64'h0);
    checkOutput("reset_cntr_addr", {62'h0, cntr_addr}, {62'h0, CNTR_CYCLE});
    rst = 1'b0; load_en = 1'b0;
    step();

    // counters frozen at 5, plain cycle read
    applyStimulus(12'hC00, 1'b0, 1'b0, t0);
    wait_idle();

    // cycle wraps while idle; high word must pick it up
    do_reset(32'hFFFF_FFF0, 32'd0);
    inc_cyc = 1;
    repeat (40) step();
    applyStimulus(12'hC80, 1'b0, 1'b0, t0);
    wait_idle();
    applyStimulus(12'hC00, 1'b0, 1'b0, t0);
    wait_idle();

    // instret wraps exactly in the ACCESS cycle of an instreth read
    do_reset(32'd100, 32'hFFFF_FFFE);
    inc_cyc = 1; inc_ins = 0;
    repeat (6) step();
    applyStimulus(12'hC82, 1'b0, 1'b1, t0);
    wait_idle();
    repeat (5) step();
    applyStimulus(12'hC82, 1'b0, 1'b0, t0);
    wait_idle();
    applyStimulus(12'hC02, 1'b0, 1'b0, t0);
    wait_idle();

    // illegal encodings and write attempts
    applyStimulus(12'hC00, 1'b1, 1'b0, t0);
    wait_idle();
    applyStimulus(12'hC83, 1'b0, 1'b0, t0);
    wait_idle();
    applyStimulus(12'h300, 1'b0, 1'b0, t0);
    wait_idle();

    // back-to-back: second request is held until the third cycle after the first
    applyStimulus(12'hC01, 1'b0, 1'b0, t0);
    applyStimulus(12'hC00, 1'b0, 1'b0, t1);
    checkOutput("b2b_accept_gap", 64'(t1 - t0), 64'd3);
    wait_idle();

    // reset during ACCESS drops the response and clears the high words
    do_reset(32'hFFFF_FFF8, 32'd0);
    inc_cyc = 1;
    repeat (20) step();
    applyStimulus(12'hC80, 1'b0, 1'b0, t0);
    wait_idle();
    applyStimulus(12'hC00, 1'b0, 1'b0, t0);
    rst = 1'b1;
    exp_q.delete();
    last_due = -10;
    #1;
    checkOutput("midreset_resp_valid", {63'h0, resp_valid}, 64'h0);
    checkOutput("midreset_req_ready", {63'h0, req_ready}, 64'h1);
    step();
    step();
    rst = 1'b0;
    repeat (4) step();
    applyStimulus(12'hC80, 1'b0, 1'b0, t0);
    wait_idle();

    // random traffic with random counter rates
    rand_inc = 1'b1;
    for (int k = 0; k < 80; k++) begin
      applyStimulus(csr_tab[$urandom_range(0, 9)], ($urandom_range(0, 7) == 0), 1'b0, t0);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) step();
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
